// File: rtl/mem_bridge_pkg.sv
// mem_bridge shared types: FSM states, transfer sizes, kseg constants.
// Imported by addr_map and mem_bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } bridge_state_t;

  typedef logic [1:0] msize_t;

  localparam msize_t MSIZE_BYTE = 2'd0;
  localparam msize_t MSIZE_HALF = 2'd1;
  localparam msize_t MSIZE_WORD = 2'd2;

  // kseg0/kseg1 window folds onto the low 512 MiB
  localparam logic [31:0] KSEG_BASE  = 32'h8000_0000;
  localparam logic [31:0] KSEG_LIMIT = 32'hBFFF_FFFF;
  localparam logic [31:0] KSEG_MASK  = 32'h1FFF_FFFF;

endpackage

// File: rtl/mem_bridge_addr_map.sv
// Virtual to physical translation for the bridge.
// kseg0/kseg1 are masked down, everything else passes through.
module addr_map
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] va_i,
  output logic [ADDR_W-1:0] pa_o
);

  localparam logic [ADDR_W-1:0] LO = ADDR_W'(KSEG_BASE);
  localparam logic [ADDR_W-1:0] HI = ADDR_W'(KSEG_LIMIT);
  localparam logic [ADDR_W-1:0] MK = ADDR_W'(KSEG_MASK);

  // fold kseg0/kseg1 onto physical space
  always_comb begin
    pa_o = va_i;
    if (va_i >= LO && va_i <= HI) begin
      pa_o = va_i & MK;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Fetch/data port arbiter onto a single SRAM-like bus.
// Optional one-entry fetch buffer: define IFETCH_BUF_EN.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_data_ok,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  bridge_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  msize_t            size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_ok_q, d_ok_q;
  logic [ADDR_W-1:0] pa;

  logic i_elig, d_elig;
  logic lat_i, lat_d;
  logic buf_hit;
  logic i_done, d_done;

  addr_map #(.ADDR_W(ADDR_W)) u_map (
    .va_i (addr_q),
    .pa_o (pa)
  );

  // a port whose ok pulse is showing has not dropped its request yet
  assign i_elig = i_req & ~i_ok_q;
  assign d_elig = d_req & ~d_ok_q;

  assign i_done = (state_q == I_DATA) & bus_data_ok;
  assign d_done = (state_q == D_DATA) & bus_data_ok;

`ifdef IFETCH_BUF_EN
  logic              bv_q;
  logic [ADDR_W-3:0] btag_q;
  logic [DATA_W-1:0] binstr_q;
  logic [ADDR_W-1:0] i_pa;
  logic [1:0]        unused_lo;

  addr_map #(.ADDR_W(ADDR_W)) u_imap (
    .va_i (i_addr),
    .pa_o (i_pa)
  );

  assign unused_lo = i_pa[1:0];
  assign buf_hit = bv_q & (btag_q == i_pa[ADDR_W-1:2]);

  // buffer fill on fetch completion, drop on aliasing store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bv_q     <= 1'b0;
      btag_q   <= '0;
      binstr_q <= '0;
    end else if (i_done) begin
      bv_q     <= 1'b1;
      btag_q   <= pa[ADDR_W-1:2];
      binstr_q <= bus_rdata;
    end else if (state_q == D_ADDR && wr_q &&
                 btag_q == pa[ADDR_W-1:2]) begin
      bv_q     <= 1'b0;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  // next state and latch enables
  always_comb begin
    state_d = state_q;
    lat_i   = 1'b0;
    lat_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d = D_ADDR;
          lat_d   = 1'b1;
        end else if (i_elig && !buf_hit) begin
          state_d = I_ADDR;
          lat_i   = 1'b1;
        end
      end
      I_ADDR: if (bus_addr_ok) state_d = I_DATA;
      I_DATA: if (bus_data_ok) state_d = IDLE;
      D_ADDR: if (bus_addr_ok) state_d = D_DATA;
      D_DATA: if (bus_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // latched request fields that drive the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= MSIZE_BYTE;
      wdata_q <= '0;
    end else if (lat_d) begin
      addr_q  <= d_addr;
      wr_q    <= d_wr;
      size_q  <= d_size;
      wdata_q <= d_wdata;
    end else if (lat_i) begin
      addr_q  <= i_addr;
      wr_q    <= 1'b0;
      size_q  <= MSIZE_WORD;
      wdata_q <= '0;
    end
  end

  // completion pulses and returned data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_ok_q    <= 1'b0;
      d_ok_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ok_q <= i_done;
      d_ok_q <= d_done;
      if (i_done) i_rdata_q <= bus_rdata;
      if (d_done && !wr_q) d_rdata_q <= bus_rdata;
`ifdef IFETCH_BUF_EN
      if (state_q == IDLE && i_elig && !d_elig && buf_hit) begin
        i_ok_q    <= 1'b1;
        i_rdata_q <= binstr_q;
      end
`endif
    end
  end

  assign bus_req   = (state_q == I_ADDR) | (state_q == D_ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = pa;
  assign bus_wdata = wdata_q;

  assign i_rdata   = i_rdata_q;
  assign i_data_ok = i_ok_q;
  assign d_rdata   = d_rdata_q;
  assign d_data_ok = d_ok_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: directed core requests,
// behavioural bus slave, monitor popping expected completions.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_data_ok;
  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];

  mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_data_ok   (i_data_ok),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_size      (d_size),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_data_ok   (d_data_ok),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // bus slave: addr_ok after addr_delay wait cycles, data_ok next cycle
  logic [31:0] mem [logic [31:0]];
  int          addr_delay = 0;
  int          wcnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = '0;
      pend        = 1'b0;
      wcnt        = 0;
    end else begin
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (pend) begin
        bus_data_ok = 1'b1;
        bus_rdata   = mem_rd(pend_addr);
        pend        = 1'b0;
      end else if (bus_req) begin
        if (wcnt < addr_delay) begin
          wcnt++;
        end else begin
          bus_addr_ok = 1'b1;
          pend        = 1'b1;
          pend_addr   = bus_addr;
          wcnt        = 0;
        end
      end
    end
  end

  // monitor: every ok pulse must match the head of its queue
  always @(negedge clk) begin
    if (!reset) begin
      if (d_data_ok) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL d_unexpected: got d_data_ok at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = dq.pop_front();
          chk({e.nm, "_rdata"}, d_rdata, e.data);
          chk({e.nm, "_cycle"}, cyc, e.cyc);
        end
      end
      if (i_data_ok) begin
        if (iq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL i_unexpected: got i_data_ok at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = iq.pop_front();
          chk({e.nm, "_rdata"}, i_rdata, e.data);
          chk({e.nm, "_cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  // core data port: hold request until ok, drop one cycle later
  task automatic core_d(input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int lat,
                        input string nm);
    exp_t e;
    int n;
    @(negedge clk);
    d_req = 1'b1;
    d_wr = wr;
    d_size = sz;
    d_addr = a;
    d_wdata = wd;
    e.data = exp_rd;
    e.cyc = cyc + lat;
    e.nm = nm;
    dq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_data_ok && n < 40);
    if (!d_data_ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no d_data_ok, required one", nm);
    end
    @(negedge clk);
    d_req = 1'b0;
  endtask

  // core fetch port
  task automatic core_i(input logic [31:0] a, input logic [31:0] exp_rd,
                        input int lat, input string nm);
    exp_t e;
    int n;
    @(negedge clk);
    i_req = 1'b1;
    i_addr = a;
    e.data = exp_rd;
    e.cyc = cyc + lat;
    e.nm = nm;
    iq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_data_ok && n < 40);
    if (!i_data_ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no i_data_ok, required one", nm);
    end
    @(negedge clk);
    i_req = 1'b0;
  endtask

  // word load with a bus-address check in the bus_req cycle
  task automatic ld_chk(input logic [31:0] a, input logic [31:0] pa,
                        input logic [31:0] exp_rd, input string nm);
    fork
      core_d(1'b0, 2'd2, a, 32'h0, exp_rd, 3, nm);
      begin
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_bus_req"}, 32'(bus_req), 32'd1);
        chk({nm, "_bus_addr"}, bus_addr, pa);
      end
    join
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required one");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    i_req = 1'b0;
    i_addr = '0;
    d_req = 1'b0;
    d_wr = 1'b0;
    d_size = '0;
    d_addr = '0;
    d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_i_ok", 32'(i_data_ok), 32'd0);
    chk("rst_d_ok", 32'(d_data_ok), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    reset = 1'b0;

    mem[32'h0000_0010] = 32'hDEAD_BEEF;
    mem[32'h0000_0020] = 32'h1111_2222;
    mem[32'h1FC0_0100] = 32'h27BD_FFE0;
    mem[32'h0000_1000] = 32'hCAFE_F00D;
    mem[32'h1FC0_0000] = 32'h3C08_BFC0;

    // kseg0 load, nominal latency
    fork
      core_d(1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 3, "ld_k0");
      begin
        @(negedge clk);
        @(negedge clk);
        chk("ld_k0_bus_req", 32'(bus_req), 32'd1);
        chk("ld_k0_bus_addr", bus_addr, 32'h0000_0010);
        chk("ld_k0_bus_wr", 32'(bus_wr), 32'd0);
        chk("ld_k0_bus_size", 32'(bus_size), 32'd2);
      end
    join

    // simultaneous requests: data first, fetch right after
    fork
      core_d(1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'h1111_2222, 3, "arb_d");
      core_i(32'hBFC0_0100, 32'h27BD_FFE0, 6, "arb_i");
      begin
        @(negedge clk);
        @(negedge clk);
        chk("arb_first_addr", bus_addr, 32'h0000_0020);
        @(negedge clk);
        @(negedge clk);
        chk("arb_gap_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        chk("arb_i_req", 32'(bus_req), 32'd1);
        chk("arb_i_addr", bus_addr, 32'h1FC0_0100);
        chk("arb_i_size", 32'(bus_size), 32'd2);
      end
    join

    // store byte to kseg1: d_rdata keeps the previous load
    fork
      core_d(1'b1, 2'd0, 32'hA000_0003, 32'h0000_00AB, 32'h1111_2222, 3,
             "st_b");
      begin
        @(negedge clk);
        @(negedge clk);
        chk("st_b_bus_req", 32'(bus_req), 32'd1);
        chk("st_b_bus_wr", 32'(bus_wr), 32'd1);
        chk("st_b_bus_size", 32'(bus_size), 32'd0);
        chk("st_b_bus_addr", bus_addr, 32'h0000_0003);
        chk("st_b_bus_wdata", bus_wdata, 32'h0000_00AB);
      end
    join

    // addr_ok withheld four cycles
    addr_delay = 4;
    fork
      core_d(1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 7, "ld_wait");
      begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("wait_bus_req", 32'(bus_req), 32'd1);
          chk("wait_bus_addr", bus_addr, 32'h0000_1000);
          chk("wait_bus_size", 32'(bus_size), 32'd2);
          chk("wait_bus_wr", 32'(bus_wr), 32'd0);
        end
      end
    join
    addr_delay = 0;

    // address-map boundaries
    ld_chk(32'hBFFF_FFFC, 32'h1FFF_FFFC, 32'h45A5_A5A6, "ld_top_k1");
    ld_chk(32'hC000_0004, 32'hC000_0004, 32'h9A5A_5A5E, "ld_k2");
    ld_chk(32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h25A5_A5A6, "ld_kuseg");

    // reset while in D_DATA abandons the transfer
    @(negedge clk);
    d_req = 1'b1;
    d_wr = 1'b0;
    d_size = 2'd2;
    d_addr = 32'h8000_0020;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    chk("rstmid_bus_req", 32'(bus_req), 32'd0);
    chk("rstmid_d_ok", 32'(d_data_ok), 32'd0);
    chk("rstmid_d_rdata", d_rdata, 32'h0);
    chk("rstmid_i_rdata", i_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_after_ok", 32'(d_data_ok), 32'd0);
    ld_chk(32'h8000_0010, 32'h0000_0010, 32'hDEAD_BEEF, "ld_fresh");

    // repeated fetch, store to the same word, fetch again
    core_i(32'hBFC0_0000, 32'h3C08_BFC0, 3, "if_1");
`ifdef IFETCH_BUF_EN
    fork
      core_i(32'hBFC0_0000, 32'h3C08_BFC0, 1, "if_hit");
      begin
        @(negedge clk);
        @(negedge clk);
        chk("if_hit_no_bus", 32'(bus_req), 32'd0);
      end
    join
`else
    core_i(32'hBFC0_0000, 32'h3C08_BFC0, 3, "if_2");
`endif
    core_d(1'b1, 2'd2, 32'h1FC0_0000, 32'h3C08_BFC0, 32'hDEAD_BEEF, 3,
           "st_inv");
    fork
      core_i(32'hBFC0_0000, 32'h3C08_BFC0, 3, "if_3");
      begin
        @(negedge clk);
        @(negedge clk);
        chk("if_3_bus_req", 32'(bus_req), 32'd1);
        chk("if_3_bus_addr", bus_addr, 32'h1FC0_0000);
      end
    join

    repeat (4) @(negedge clk);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
